// File: rtl/stack_alu_sequencer.sv
// stack_alu_sequencer: replays a loaded {opcode, operand} program onto a stack ALU, capturing pops and overflow.
// Optional `STACK_SEQ_STEP_EN adds a step input that gates each FETCH.
module stack_alu_sequencer #(
  parameter int N     = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          CLK,
  input  logic          RST_N,
`ifdef STACK_SEQ_STEP_EN
  input  logic          step,
`endif
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [N+2:0]  load_word,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [2:0]    alu_opcode,
  output logic [N-1:0]  alu_data,
  input  logic [N-1:0]  alu_result,
  input  logic          alu_overflow,
  output logic [N-1:0]  result,
  output logic          result_valid,
  output logic          ovf_sticky,
  output logic [AW-1:0] pc
);
  typedef enum logic [2:0] {IDLE, FETCH, ISSUE, GAP, DONE} state_t;
  state_t state_q, state_d;
  logic [N+2:0] mem [DEPTH];
  logic [N+2:0] word;
  logic [AW-1:0] pc_q, pc_d;
  logic [2:0] op_q, op_d, alu_opcode_q, alu_opcode_d;
  logic [N-1:0] alu_data_q, alu_data_d, result_q, result_d;
  logic rv_q, rv_d, ovf_q, ovf_d, busy_q, busy_d, done_q, done_d;
  logic go, halt, last;
  assign word = mem[pc_q];
  assign halt = word[N+2:N] == 3'b001;
  assign last = pc_q == AW'(DEPTH - 1);
`ifdef STACK_SEQ_STEP_EN
  assign go = step;
`else
  assign go = 1'b1;
`endif
  // Loads are only accepted in IDLE, so a start in the same cycle sees the new word.
  always_ff @(posedge CLK)
    if (load_en && state_q == IDLE) mem[load_addr] <= load_word;
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      state_q      <= IDLE;
      pc_q         <= '0;
      op_q         <= 3'b000;
      alu_opcode_q <= 3'b000;
      alu_data_q   <= '0;
      result_q     <= '0;
      rv_q         <= 1'b0;
      ovf_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      op_q         <= op_d;
      alu_opcode_q <= alu_opcode_d;
      alu_data_q   <= alu_data_d;
      result_q     <= result_d;
      rv_q         <= rv_d;
      ovf_q        <= ovf_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start ? FETCH : IDLE;
      FETCH:   state_d = !go ? FETCH : halt ? DONE : ISSUE;
      ISSUE:   state_d = GAP;
      GAP:     state_d = last ? DONE : FETCH;
      default: state_d = IDLE;
    endcase
  end
  // op_q remembers the issued opcode through GAP, where the ALU pins already read 000.
  always_comb begin
    pc_d         = pc_q;
    op_d         = op_q;
    alu_opcode_d = 3'b000;
    alu_data_d   = alu_data_q;
    result_d     = result_q;
    rv_d         = 1'b0;
    ovf_d        = ovf_q;
    busy_d       = state_d != IDLE;
    done_d       = state_d == DONE;
    if (state_q == IDLE && start) begin
      pc_d  = '0;
      ovf_d = 1'b0;
    end
    if (state_q == FETCH && go && !halt) begin
      alu_opcode_d = word[N+2:N];
      alu_data_d   = word[N-1:0];
      op_d         = word[N+2:N];
    end
    if (state_q == GAP) begin
      pc_d     = pc_q + 1'b1;
      result_d = op_q == 3'b111 ? alu_result : result_q;
      rv_d     = op_q == 3'b111;
      ovf_d    = ovf_q | (op_q[2:1] == 2'b10 && alu_overflow);
    end
  end
  assign busy         = busy_q;
  assign done         = done_q;
  assign alu_opcode   = alu_opcode_q;
  assign alu_data     = alu_data_q;
  assign result       = result_q;
  assign result_valid = rv_q;
  assign ovf_sticky   = ovf_q;
  assign pc           = pc_q;
endmodule

// File: tb/tb_stack_alu_sequencer.sv
// tb_stack_alu_sequencer: directed and random programs against a stack-ALU model and a program-level reference.
module tb_stack_alu_sequencer;
  localparam logic [2:0] NOP = 3'b000, HALT = 3'b001, ADD = 3'b100, MUL = 3'b101, PUSH = 3'b110, POP = 3'b111;
  logic CLK = 0, RST_N = 1, load_en = 0, start = 0;
  logic [3:0] load_addr = 0;
  logic [10:0] load_word = 0;
  logic busy, done, result_valid, ovf_sticky, alu_overflow = 0;
  logic [2:0] alu_opcode;
  logic [7:0] alu_data, result, alu_result = 0;
  logic [3:0] pc;
`ifdef STACK_SEQ_STEP_EN
  logic step = 1;
`endif
  int tests = 0, fails = 0;
  logic [10:0] prog [16];
  logic [10:0] trace [$], exp_trace [$];
  int rv_cnt = 0, exp_lat, exp_pc, exp_pops;
  logic exp_ovf;
  logic [7:0] exp_result = 0;

  stack_alu_sequencer dut (
    .CLK(CLK), .RST_N(RST_N),
`ifdef STACK_SEQ_STEP_EN
    .step(step),
`endif
    .load_en(load_en), .load_addr(load_addr), .load_word(load_word), .start(start),
    .busy(busy), .done(done), .alu_opcode(alu_opcode), .alu_data(alu_data),
    .alu_result(alu_result), .alu_overflow(alu_overflow), .result(result),
    .result_valid(result_valid), .ovf_sticky(ovf_sticky), .pc(pc)
  );

  always #5 CLK = ~CLK;

  // Stack ALU stand-in: acts on the pins sampled at each edge; overflow flags only the op just executed.
  logic [7:0] stk [$];
  logic [7:0] ua, ub;
  int ur;
  always @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      stk.delete();
      alu_result <= 0;
      alu_overflow <= 0;
    end else begin
      alu_overflow <= 0;
      if (alu_opcode == PUSH) stk.push_back(alu_data);
      else if ((alu_opcode == ADD || alu_opcode == MUL) && stk.size() >= 2) begin
        ub = stk.pop_back();
        ua = stk.pop_back();
        ur = alu_opcode == ADD ? int'($signed(ua)) + int'($signed(ub)) : int'($signed(ua)) * int'($signed(ub));
        stk.push_back(ur[7:0]);
        alu_overflow <= ur > 127 || ur < -128;
      end else if (alu_opcode == POP && stk.size() > 0) alu_result <= stk.pop_back();
    end

  always @(posedge CLK)
    if (RST_N) begin
      if (alu_opcode != NOP) trace.push_back({alu_opcode, alu_data});
      if (result_valid) rv_cnt++;
    end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Program semantics: signed N-bit stack arithmetic, 3 cycles per slot before HALT, 48 on wrap.
  task automatic model();
    logic [7:0] q [$];
    logic [7:0] a, b;
    logic [2:0] op;
    int r, h;
    exp_trace.delete();
    exp_ovf = 0;
    exp_pops = 0;
    h = 16;
    for (int i = 0; i < 16; i++) if (prog[i][10:8] == HALT) begin h = i; break; end
    exp_lat = h < 16 ? 3 * h + 1 : 48;
    exp_pc = h < 16 ? h : 0;
    for (int i = 0; i < h; i++) begin
      op = prog[i][10:8];
      if (op != NOP) exp_trace.push_back(prog[i]);
      if (op == PUSH) q.push_back(prog[i][7:0]);
      else if (op == ADD || op == MUL) begin
        b = q.pop_back();
        a = q.pop_back();
        r = op == ADD ? int'($signed(a)) + int'($signed(b)) : int'($signed(a)) * int'($signed(b));
        if (r > 127 || r < -128) exp_ovf = 1;
        q.push_back(8'(r));
      end else if (op == POP) begin
        exp_pops++;
        exp_result = q.pop_back();
      end
    end
  endtask

  task automatic set5(input logic [10:0] p0, p1, p2, p3, p4);
    foreach (prog[i]) prog[i] = 0;
    prog[0] = p0; prog[1] = p1; prog[2] = p2; prog[3] = p3; prog[4] = p4;
  endtask

  task automatic load_all(input int from);
    for (int i = from; i < 16; i++) begin
      load_en = 1; load_addr = 4'(i); load_word = prog[i];
      @(posedge CLK); #1;
    end
    load_en = 0;
  endtask

  task automatic rand_prog();
    int d = 0;
    logic [2:0] o;
    for (int i = 0; i < 16; i++) begin
      if ($urandom_range(0, 11) == 0) prog[i] = {HALT, 8'($urandom)};
      else case ($urandom_range(0, 4))
        2: if (d >= 2) begin prog[i] = {$urandom_range(0, 1) ? ADD : MUL, 8'($urandom)}; d--; end
           else begin prog[i] = {PUSH, 8'($urandom)}; d++; end
        3: if (d >= 1) begin prog[i] = {POP, 8'($urandom)}; d--; end
           else begin prog[i] = {PUSH, 8'($urandom)}; d++; end
        4: begin o = 3'($urandom_range(0, 2)); prog[i] = {o == 0 ? NOP : o + 3'd1, 8'($urandom)}; end
        default: begin prog[i] = {PUSH, 8'($urandom)}; d++; end
      endcase
    end
  endtask

  task automatic run(input string tag, input bit simul, input bit junk);
    int cyc;
    bit ok;
    model();
    trace.delete();
    rv_cnt = 0;
    if (simul) begin load_en = 1; load_addr = 0; load_word = prog[0]; end
    start = 1;
    @(posedge CLK); #1;
    start = 0;
    load_en = 0;
    chk({tag, "/busy_up"}, busy, 1);
    chk({tag, "/ovf_clr"}, ovf_sticky, 0);
    if (junk) begin load_en = 1; load_addr = 0; load_word = {PUSH, 8'd99}; end
    cyc = 0;
    while (done !== 1 && cyc < 200) begin @(posedge CLK); #1; cyc++; end
    load_en = 0;
    chk({tag, "/latency"}, cyc, exp_lat);
    chk({tag, "/pc"}, pc, exp_pc);
    @(posedge CLK); #1;
    chk({tag, "/done_pulse"}, {done, busy}, 0);
    chk({tag, "/result"}, result, exp_result);
    chk({tag, "/ovf"}, ovf_sticky, exp_ovf);
    chk({tag, "/rv_count"}, rv_cnt, exp_pops);
    ok = trace.size() == exp_trace.size();
    if (ok) foreach (trace[i]) if (trace[i] !== exp_trace[i]) ok = 0;
    chk({tag, "/alu_trace"}, ok, 1);
  endtask

  initial begin
    #2 RST_N = 0;
    #2 chk("reset", {busy, done, alu_opcode, alu_data, result, result_valid, ovf_sticky, pc}, 0);
    repeat (2) @(posedge CLK);
    #1 RST_N = 1;
    set5({PUSH, 8'd14}, {PUSH, 8'd7}, {ADD, 8'd0}, {POP, 8'd0}, {HALT, 8'd0});
    load_all(0);
    run("add", 0, 1);
    set5({PUSH, 8'hFC}, {PUSH, 8'hFA}, {MUL, 8'd0}, {POP, 8'd0}, {HALT, 8'd0});
    load_all(1);
    run("mul_simul_load", 1, 0);
    set5({PUSH, 8'd100}, {PUSH, 8'd100}, {ADD, 8'd0}, {POP, 8'd0}, {HALT, 8'd0});
    load_all(0);
    run("ovf", 0, 0);
    foreach (prog[i]) prog[i] = 0;
    load_all(0);
    run("wrap", 0, 0);
    for (int k = 0; k < 8; k++) begin
      rand_prog();
      load_all(0);
      run($sformatf("rand%0d", k), 0, 0);
    end
    set5({PUSH, 8'd14}, {PUSH, 8'd7}, {ADD, 8'd0}, {POP, 8'd0}, {HALT, 8'd0});
    load_all(0);
    start = 1;
    @(posedge CLK); #1;
    start = 0;
    repeat (4) begin @(posedge CLK); #1; end
    chk("mid_issue", {alu_opcode, alu_data}, {PUSH, 8'd7});
    RST_N = 0;
    #1 chk("mid_reset", {busy, done, alu_opcode, alu_data, result, result_valid, ovf_sticky, pc}, 0);
    exp_result = 0;
    repeat (2) @(posedge CLK);
    #1 RST_N = 1;
    run("rerun", 0, 0);
`ifdef STACK_SEQ_STEP_EN
    step = 0;
    start = 1;
    @(posedge CLK); #1;
    start = 0;
    repeat (20) @(posedge CLK);
    #1 chk("step_hold", {pc, alu_opcode, busy}, {4'd0, NOP, 1'b1});
    repeat (5) begin
      step = 1;
      @(posedge CLK); #1;
      step = 0;
      repeat (3) begin @(posedge CLK); #1; end
    end
    chk("step_run", {result, busy}, {8'd21, 1'b0});
    step = 1;
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
